// File: rtl/mix_columns_sequencer_if.sv
// Handshake bundle for the MixColumns sequencer: an input state channel and a mixed-state
// output channel, each valid/ready, plus a busy status flag.
interface mix_columns_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_sequencer.sv
// AES MixColumns over a full 128-bit state, one column per clock through a single shared
// column multiplier. Bypass returns the captured state unchanged for the final round.
module mix_columns_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  mix_columns_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [1:0]   col_q, col_d;
  logic [31:0]  col_word_s;
  logic [31:0]  mixed_s;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Column word is {a0,a1,a2,a3} with a0 in the top byte, matching the state byte order.
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
            mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Multiplier input mux: pick column col_q out of the working register.
  always_comb begin
    col_word_s = buf_q[127:96];
    case (col_q)
      2'd0:    col_word_s = buf_q[127:96];
      2'd1:    col_word_s = buf_q[95:64];
      2'd2:    col_word_s = buf_q[63:32];
      2'd3:    col_word_s = buf_q[31:0];
      default: col_word_s = buf_q[127:96];
    endcase
    mixed_s = mix_column(col_word_s);
  end

  // Next-state, column counter and working-register update.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    col_d   = col_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          buf_d = bus.in_state;
          col_d = 2'd0;
          if (bus.in_bypass) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_MIX;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MIX: begin
        case (col_q)
          2'd0:    buf_d[127:96] = mixed_s;
          2'd1:    buf_d[95:64]  = mixed_s;
          2'd2:    buf_d[63:32]  = mixed_s;
          2'd3:    buf_d[31:0]   = mixed_s;
          default: buf_d         = buf_q;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MIX;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        col_d   = 2'd0;
      end
    endcase
  end

  // State, counter and working register; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      buf_q   <= 128'h0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      col_q   <= col_d;
    end
  end

  // Handshake outputs decode registered state only, so no input reaches an output combinationally.
  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_state = buf_q;

endmodule

// File: doc/mix_columns_sequencer.md
# mix_columns_sequencer

Sequences one AES MixColumns transform over a full 128-bit state using a single shared one-column GF(2^8) multiply unit, processing one column per clock. It sits between ShiftRows and AddRoundKey in the round datapath. It accepts a state over a valid/ready handshake and returns the mixed state over a second valid/ready handshake. A per-transaction bypass passes the state through unchanged for the final AES round.

## Interface
- No parameters. Widths are fixed by AES.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  `in_state`/`in_bypass` valid.
- `in_ready`  out  1  block can accept; equals (FSM == IDLE).
- `in_state`  in  128  input state; byte s0 at [127:120] … s15 at [7:0]; column c = bytes s(4c)..s(4c+3).
- `in_bypass`  in  1  1 = final round, output equals input, no mixing.
- `out_valid`  out  1  `out_state` holds the result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  128  result state register, same byte order as `in_state`.
- `busy`  out  1  FSM != IDLE.

## Operation
- Internals:
  - 128-bit working register `buf`, which drives `out_state` directly.
  - 2-bit column counter `col`.
  - One combinational column multiplier: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00); 3x = xtime(x)^x. All arithmetic is 8-bit GF(2^8), no carries.
- Exactly one multiplier instance. Its input mux selects column `col` of `buf`.
- FSM states: IDLE, MIX, DONE.
  - IDLE:
    - On in_valid && in_ready: `buf` <= `in_state`, `col` <= 0.
    - Next state is DONE if `in_bypass` = 1, else MIX.
    - Otherwise hold.
  - MIX:
    - Each cycle, column `col` of `buf` <= multiplier output; `col` <= `col`+1.
    - When `col` == 3, go to DONE; `col` wraps to 0.
    - Inputs are ignored (in_ready = 0).
  - DONE:
    - out_valid = 1 and `buf` frozen.
    - On out_ready, go to IDLE. Otherwise hold indefinitely.
- `in_bypass` is sampled only at the accept edge. Later changes have no effect.
- `in_state` is sampled only at the accept edge. Later changes have no effect.
- out_valid = (FSM == DONE), decoded from registered state, with no combinational path from inputs.
- in_ready = (FSM == IDLE), likewise registered-decoded. There is no in→out combinational path.
- No new input is accepted in the cycle DONE→IDLE. The earliest next accept is the edge after the out handshake.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - FSM = IDLE, `col` = 0, `buf` = 128'h0.
  - Hence in_ready = 1, out_valid = 0, busy = 0, out_state = 0.
- Reset deassertion takes effect at the first rising edge after release.
- Reset asserted mid-MIX or in DONE: the partial result is discarded, outputs return to reset values immediately, and no output handshake occurs.
- Normal transaction, accept at edge k:
  - Columns 0,1,2,3 are written at edges k+1..k+4.
  - out_valid is high after edge k+4 (4-cycle latency).
- Bypass transaction, accept at edge k: out_valid is high after edge k (1 cycle), out_state = in_state.
- Output handshake completes at the edge where out_valid && out_ready. in_ready rises after that edge.
- Throughput:
  - 6 cycles per mixed state with out_ready held high (accept, 4 mix, done).
  - 2 cycles per bypassed state.
- out_ready asserted while out_valid = 0 has no effect.
- out_ready held low keeps out_valid and out_state stable.

## Test plan
- Reset then single mix:
  - State columns db135345 | f20a225c | 01010101 | c6c6c6c6, bypass=0, out_ready=1.
  - Required: out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - out_valid rises exactly 4 cycles after the accept edge.
- Second vector:
  - Columns d4d4d4d5 | 2d26314c | 00000000 | ffffffff.
  - Required: d5d5d7d6_4d7ebdf8_00000000_ffffffff.
- Bypass:
  - in_state = 00112233_44556677_8899aabb_ccddeeff, bypass=1.
  - Required: identical out_state, with out_valid 1 cycle after accept.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid.
  - Required: out_state stable, in_ready=0 throughout, and an offered second input is not accepted until 1 cycle after the out handshake.
- Reset mid-MIX:
  - Drop rst_n two cycles after accept.
  - Required: out_valid=0, out_state=0, in_ready=1 immediately.
  - The next transaction completes correctly.
- Back-to-back:
  - 3 transactions with in_valid and out_ready held high.
  - Required: each result correct, and accepts spaced exactly 6 cycles apart.
